// File: rtl/clint_pkg.sv
// Shared register offsets, reset constants and byte-merge helper for the CLINT.
// Build option: CLINT_PRESCALER_REG_EN adds a writable tick divisor register.
package clint_pkg;

    localparam logic [15:0] MSIP_BASE      = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE  = 16'h4000;
    localparam logic [15:0] MTIME_LO       = 16'hBFF8;
    localparam logic [15:0] MTIME_HI       = 16'hBFFC;
    localparam logic [15:0] PRESC_OFF      = 16'hBFF0;
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdat,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler: counts 0..div-1 and pulses tick on the cycle it wraps to 0.
// A divisor of 0 behaves like 1 (tick every cycle).
module clint_tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [31:0] div,
    output logic        tick
);

    logic [31:0] cnt;
    logic [31:0] last;

    assign last = (div == 32'd0) ? 32'd0 : div - 32'd1;
    // >= so that shrinking the divisor never strands the count above it
    assign tick = (cnt >= last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: 64-bit mtime, per-hart mtimecmp/msip, Wishbone classic slave.
// Build option: CLINT_PRESCALER_REG_EN exposes the tick divisor at 0xBFF0.
module clint_mh
    import clint_pkg::*;
#(
    parameter int NUM_HARTS = 1,
    parameter int TICK_DIV  = 1526
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic [31:0]          adr_i,
    input  logic                 we_i,
    input  logic [3:0]           sel_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic [NUM_HARTS-1:0] timer_irq_o,
    output logic [NUM_HARTS-1:0] soft_irq_o
);

    logic [15:0]          off;
    logic                 req;
    logic                 wr;
    logic [3:0]           msip_idx;
    logic [3:0]           cmp_idx;
    logic                 msip_hit;
    logic                 cmp_hit;
    logic                 time_lo_hit;
    logic                 time_hi_hit;
    logic [63:0]          mtime;
    logic [63:0]          mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip;
    logic [31:0]          rdata;
    logic [31:0]          div;
    logic                 clr;
    logic                 tick;
    logic                 unused;

    assign off         = {adr_i[15:2], 2'b00};
    assign unused      = ^{adr_i[31:16], adr_i[1:0]};
    assign req         = cyc_i & stb_i & ~ack_o;
    assign wr          = req & we_i;
    assign msip_idx    = off[5:2];
    assign cmp_idx     = off[6:3];
    assign msip_hit    = (off[15:6] == MSIP_BASE[15:6]) &&
                         (int'(msip_idx) < NUM_HARTS);
    assign cmp_hit     = (off[15:7] == MTIMECMP_BASE[15:7]) &&
                         (int'(cmp_idx) < NUM_HARTS);
    assign time_lo_hit = (off == MTIME_LO);
    assign time_hi_hit = (off == MTIME_HI);
    assign soft_irq_o  = msip;

`ifdef CLINT_PRESCALER_REG_EN
    logic [31:0] presc;
    logic [31:0] presc_new;
    logic        presc_hit;

    assign presc_hit = (off == PRESC_OFF);
    assign presc_new = merge_bytes(presc, dat_i, sel_i);
    assign clr       = wr & presc_hit;
    assign div       = presc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc <= 32'(TICK_DIV);
        end else if (clr) begin
            presc <= (presc_new == 32'd0) ? 32'd1 : presc_new;
        end
    end
`else
    assign clr = 1'b0;
    assign div = 32'(TICK_DIV);
`endif

    clint_tick_gen u_tick (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        rdata = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (msip_hit && msip_idx == 4'(h)) rdata = {31'd0, msip[h]};
            if (cmp_hit && cmp_idx == 4'(h)) begin
                rdata = off[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
            end
        end
        if (time_lo_hit) rdata = mtime[31:0];
        if (time_hi_hit) rdata = mtime[63:32];
`ifdef CLINT_PRESCALER_REG_EN
        if (presc_hit) rdata = presc;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime       <= '0;
            msip        <= '0;
            ack_o       <= 1'b0;
            dat_o       <= '0;
            timer_irq_o <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= MTIMECMP_RESET;
        end else begin
            ack_o <= req;
            dat_o <= req ? rdata : 32'd0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                timer_irq_o[h] <= (mtime >= mtimecmp[h]);
                if (wr && msip_hit && msip_idx == 4'(h) && sel_i[0]) begin
                    msip[h] <= dat_i[0];
                end
                if (wr && cmp_hit && cmp_idx == 4'(h)) begin
                    if (off[2]) begin
                        mtimecmp[h][63:32] <=
                            merge_bytes(mtimecmp[h][63:32], dat_i, sel_i);
                    end else begin
                        mtimecmp[h][31:0] <=
                            merge_bytes(mtimecmp[h][31:0], dat_i, sel_i);
                    end
                end
            end
            // a bus write to either mtime word suppresses that cycle's tick
            if (wr && time_lo_hit) begin
                mtime[31:0] <= merge_bytes(mtime[31:0], dat_i, sel_i);
            end else if (wr && time_hi_hit) begin
                mtime[63:32] <= merge_bytes(mtime[63:32], dat_i, sel_i);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

endmodule
